// File: rtl/v_alu_exec.sv
// v_alu_exec: vector execute stage.
// Single-cycle VADD/VMUL/VMAX/NOP and a 16-step restoring signed divider
// that runs all lanes in lock-step from one shared step counter.
// Holds one op at a time. Valid/ready handshakes on both sides.
module v_alu_exec #(
  parameter int VALUOP_DW = 5,
  parameter int VREG_DW   = 512,
  parameter int VREG_AW   = 5,
  parameter int SEW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [VALUOP_DW-1:0] valu_opcode_i,
  input  logic [VREG_DW-1:0]   operand_v1_i,
  input  logic [VREG_DW-1:0]   operand_v2_i,
  input  logic                 wb_en_i,
  input  logic [VREG_AW-1:0]   wb_addr_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [VREG_DW-1:0]   result_o,
  output logic                 wb_en_o,
  output logic [VREG_AW-1:0]   wb_addr_o,
  output logic                 busy_o
);

  localparam int LANES = VREG_DW / SEW;
  localparam int CW    = $clog2(SEW);
  localparam logic [CW-1:0] CNT_LAST = CW'(SEW - 1);

  localparam logic [VALUOP_DW-1:0] OP_NOP  = VALUOP_DW'(0);
  localparam logic [VALUOP_DW-1:0] OP_VMUL = VALUOP_DW'(1);
  localparam logic [VALUOP_DW-1:0] OP_VADD = VALUOP_DW'(2);
  localparam logic [VALUOP_DW-1:0] OP_VDIV = VALUOP_DW'(3);
  localparam logic [VALUOP_DW-1:0] OP_VMAX = VALUOP_DW'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            accept;
  logic            is_div;
  logic            op_writes;

  // Per-lane single-cycle datapath.
  logic [SEW-1:0]     lane_a, lane_b;
  logic [VREG_DW-1:0] fast_res;

  // Divider operand prep at accept time.
  logic [LANES-1:0][SEW-1:0] mag1, mag2;
  logic [LANES-1:0]          neg_in, dz_in, ovf_in;

  // Divider working state, one set per lane.
  logic [LANES-1:0][SEW-1:0] quo_q, dvs_q;
  logic [LANES-1:0][SEW:0]   rem_q;
  logic [LANES-1:0]          neg_q, dz_q, ovf_q;

  // Divider next-step values.
  logic [SEW:0]              shifted;
  logic [LANES-1:0][SEW-1:0] quo_n;
  logic [LANES-1:0][SEW:0]   rem_n;
  logic [VREG_DW-1:0]        div_res;

  assign ready_o   = (state_q == S_IDLE);
  assign busy_o    = (state_q != S_IDLE);
  assign valid_o   = (state_q == S_DONE);
  assign accept    = valid_i & ready_o;
  assign is_div    = (valu_opcode_i == OP_VDIV);
  assign op_writes = valu_opcode_i inside {OP_VMUL, OP_VADD, OP_VDIV, OP_VMAX};

  // Lane-wise add / multiply / signed max; NOP and unknown opcodes give zero.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
    fast_res = '0;
    lane_a   = '0;
    lane_b   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = operand_v2_i[i*SEW +: SEW];
      lane_b = operand_v1_i[i*SEW +: SEW];
      case (valu_opcode_i)
        OP_VADD: fast_res[i*SEW +: SEW] = lane_a + lane_b;
        OP_VMUL: fast_res[i*SEW +: SEW] = lane_a * lane_b;
        OP_VMAX: fast_res[i*SEW +: SEW] = ($signed(lane_a) > $signed(lane_b)) ? lane_a : lane_b;
        OP_NOP:  fast_res[i*SEW +: SEW] = '0;
        default: fast_res[i*SEW +: SEW] = '0;
      endcase
    end
  end

  // Magnitudes, quotient sign and special-case flags for a divide being accepted.
  always_comb begin
    mag1   = '0;
    mag2   = '0;
    neg_in = '0;
    dz_in  = '0;
    ovf_in = '0;
    for (int i = 0; i < LANES; i++) begin
      mag1[i]   = operand_v1_i[i*SEW+SEW-1] ? -operand_v1_i[i*SEW +: SEW] : operand_v1_i[i*SEW +: SEW];
      mag2[i]   = operand_v2_i[i*SEW+SEW-1] ? -operand_v2_i[i*SEW +: SEW] : operand_v2_i[i*SEW +: SEW];
      neg_in[i] = operand_v1_i[i*SEW+SEW-1] ^ operand_v2_i[i*SEW+SEW-1];
      dz_in[i]  = (operand_v1_i[i*SEW +: SEW] == '0);
      ovf_in[i] = (operand_v2_i[i*SEW +: SEW] == {1'b1, {(SEW-1){1'b0}}}) &&
                  (operand_v1_i[i*SEW +: SEW] == '1);
    end
  end

  // One restoring step per lane, plus the sign fix applied to the final step's quotient.
  always_comb begin
    shifted = '0;
    quo_n   = '0;
    rem_n   = '0;
    div_res = '0;
    for (int i = 0; i < LANES; i++) begin
      shifted = {rem_q[i][SEW-1:0], quo_q[i][SEW-1]};
      if (shifted >= {1'b0, dvs_q[i]}) begin
        rem_n[i] = shifted - {1'b0, dvs_q[i]};
        quo_n[i] = {quo_q[i][SEW-2:0], 1'b1};
      end else begin
        rem_n[i] = shifted;
        quo_n[i] = {quo_q[i][SEW-2:0], 1'b0};
      end
      if (dz_q[i])
        div_res[i*SEW +: SEW] = '1;
      else if (ovf_q[i])
        div_res[i*SEW +: SEW] = {1'b1, {(SEW-1){1'b0}}};
      else if (neg_q[i])
        div_res[i*SEW +: SEW] = -quo_n[i];
      else
        div_res[i*SEW +: SEW] = quo_n[i];
    end
  end

  // Next-state logic: IDLE accepts, DIV counts SEW steps, DONE waits for the handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_div ? S_DIV : S_DONE;
      S_DIV:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE: if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Divide step counter: cleared on accept, advances once per DIV cycle.
  always_ff @(posedge clk) begin
    if (!rst)                  cnt_q <= '0;
    else if (accept)           cnt_q <= '0;
    else if (state_q == S_DIV) cnt_q <= cnt_q + 1'b1;
  end

  // Output registers: written at accept (tag, fast result) and at the last divide step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_o  <= '0;
      wb_en_o   <= 1'b0;
      wb_addr_o <= '0;
    end else if (accept) begin
      wb_en_o   <= wb_en_i & op_writes;
      wb_addr_o <= wb_addr_i;
      if (!is_div) result_o <= fast_res;
    end else if (state_q == S_DIV && cnt_q == CNT_LAST) begin
      result_o <= div_res;
    end
  end

  // Divider datapath registers, loaded on a divide accept and stepped while in DIV.
  always_ff @(posedge clk) begin
    // NOTE: these wide per-lane registers carry no reset; the FSM never reads them before a load.
    if (accept && is_div) begin
      quo_q <= mag2;
      dvs_q <= mag1;
      rem_q <= '0;
      neg_q <= neg_in;
      dz_q  <= dz_in;
      ovf_q <= ovf_in;
    end else if (state_q == S_DIV) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
    end
  end

endmodule

// File: tb/tb_v_alu_exec.sv
// tb_v_alu_exec: directed and randomized checks of v_alu_exec against an
// integer-arithmetic lane model.
module tb_v_alu_exec;

  localparam int DW    = 512;
  localparam int AW    = 5;
  localparam int OW    = 5;
  localparam int LANES = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [OW-1:0] valu_opcode_i;
  logic [DW-1:0] operand_v1_i;
  logic [DW-1:0] operand_v2_i;
  logic          wb_en_i;
  logic [AW-1:0] wb_addr_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] result_o;
  logic          wb_en_o;
  logic [AW-1:0] wb_addr_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  v_alu_exec dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .valu_opcode_i (valu_opcode_i),
    .operand_v1_i  (operand_v1_i),
    .operand_v2_i  (operand_v2_i),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .wb_en_o       (wb_en_o),
    .wb_addr_o     (wb_addr_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference lane result: result = v2 OP v1, signed 16-bit lanes.
  function automatic logic [15:0] lane_ref(input int op, input logic [15:0] x1, input logic [15:0] x2);
    int a, b, r;
    a = $signed(x2);
    b = $signed(x1);
    case (op)
      1: r = a * b;
      2: r = a + b;
      3: begin
        if (b == 0)                      r = -1;
        else if (a == -32768 && b == -1) r = -32768;
        else                             r = a / b;
      end
      4: r = (a > b) ? a : b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [DW-1:0] vec_ref(input int op, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*16 +: 16] = lane_ref(op, v1[i*16 +: 16], v2[i*16 +: 16]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue one op, wait (bounded) for the result, check it, hold under backpressure, then handshake.
  task automatic run_op(input int op, input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                        input logic en, input logic [AW-1:0] addr, input int hold,
                        output logic [DW-1:0] got, output logic got_en);
    logic [DW-1:0] exp;
    logic          exp_en;
    int            lat;
    exp    = vec_ref(op, v1, v2);
    exp_en = en && (op >= 1 && op <= 4);
    check("ready_before_accept", DW'(ready_o), DW'(1'b1));
    valu_opcode_i = OW'(op);
    operand_v1_i  = v1;
    operand_v2_i  = v2;
    wb_en_i       = en;
    wb_addr_i     = addr;
    valid_i       = 1'b1;
    step();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 40) begin
      check("ready_low_while_div", DW'(ready_o), DW'(1'b0));
      operand_v1_i = rand_vec();
      operand_v2_i = rand_vec();
      wb_addr_i    = AW'($urandom);
      step();
      lat++;
    end
    check("latency", DW'(lat), DW'((op == 3) ? 17 : 1));
    check("result", result_o, exp);
    check("wb_en", DW'(wb_en_o), DW'(exp_en));
    check("wb_addr", DW'(wb_addr_o), DW'(addr));
    for (int k = 0; k < hold; k++) begin
      valid_i       = 1'($urandom_range(0, 1));
      valu_opcode_i = OW'(2);
      operand_v1_i  = rand_vec();
      operand_v2_i  = rand_vec();
      step();
      check("hold_valid", DW'(valid_o), DW'(1'b1));
      check("hold_ready", DW'(ready_o), DW'(1'b0));
      check("hold_result", result_o, exp);
      check("hold_wb_addr", DW'(wb_addr_o), DW'(addr));
    end
    valid_i = 1'b0;
    got     = result_o;
    got_en  = wb_en_o;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check("valid_drop_after_hs", DW'(valid_o), DW'(1'b0));
    check("ready_after_hs", DW'(ready_o), DW'(1'b1));
    check("busy_after_hs", DW'(busy_o), DW'(1'b0));
  endtask

  initial begin
    logic [DW-1:0] v1, v2, got;
    logic          got_en;
    logic          seen_valid;
    int            op;

    rst           = 1'b0;
    valid_i       = 1'b0;
    ready_i       = 1'b0;
    valu_opcode_i = '0;
    operand_v1_i  = '0;
    operand_v2_i  = '0;
    wb_en_i       = 1'b0;
    wb_addr_i     = '0;

    // Reset state
    repeat (3) step();
    check("rst_valid", DW'(valid_o), DW'(1'b0));
    check("rst_result", result_o, '0);
    check("rst_wb_en", DW'(wb_en_o), DW'(1'b0));
    check("rst_wb_addr", DW'(wb_addr_o), DW'(0));
    rst = 1'b1;
    step();
    check("rst_ready", DW'(ready_o), DW'(1'b1));
    check("rst_busy", DW'(busy_o), DW'(1'b0));

    // VADD overflow wrap on every lane
    v1 = {LANES{16'h0001}};
    v2 = {LANES{16'h7FFF}};
    run_op(2, v1, v2, 1'b1, 5'd9, 0, got, got_en);
    check("vadd_const", got, {LANES{16'h8000}});

    // VMUL low half of signed product
    v1 = '0; v2 = '0;
    v2[15:0] = 16'hFFFD; v1[15:0] = 16'h0005;
    v2[31:16] = 16'h0100; v1[31:16] = 16'h0100;
    run_op(1, v1, v2, 1'b1, 5'd3, 0, got, got_en);
    check("vmul_lane0", DW'(got[15:0]), DW'(16'hFFF1));
    check("vmul_lane1", DW'(got[31:16]), DW'(16'h0000));

    // VDIV directed cases, remaining lanes random
    v1 = rand_vec(); v2 = rand_vec();
    v2[15:0]  = 16'hFFF9; v1[15:0]  = 16'h0002;
    v2[31:16] = 16'h0007; v1[31:16] = 16'h0000;
    v2[47:32] = 16'h8000; v1[47:32] = 16'hFFFF;
    v2[63:48] = 16'd100;  v1[63:48] = 16'hFFF9;
    run_op(3, v1, v2, 1'b1, 5'd17, 0, got, got_en);
    check("vdiv_neg7_2", DW'(got[15:0]), DW'(16'hFFFD));
    check("vdiv_by_zero", DW'(got[31:16]), DW'(16'hFFFF));
    check("vdiv_ovf", DW'(got[47:32]), DW'(16'h8000));
    check("vdiv_100_neg7", DW'(got[63:48]), DW'(16'hFFF2));

    // VMAX signed compare
    v1 = '0; v2 = '0;
    v2[15:0]  = 16'hFFFF; v1[15:0]  = 16'h0003;
    v2[31:16] = 16'h8000; v1[31:16] = 16'h7FFF;
    run_op(4, v1, v2, 1'b1, 5'd1, 0, got, got_en);
    check("vmax_lane0", DW'(got[15:0]), DW'(16'h0003));
    check("vmax_lane1", DW'(got[31:16]), DW'(16'h7FFF));

    // Unknown opcode: zero result, no writeback
    run_op(7, rand_vec(), rand_vec(), 1'b1, 5'd30, 0, got, got_en);
    check("op7_result", got, '0);
    check("op7_wb_en", DW'(got_en), DW'(1'b0));

    // Backpressure for 5 cycles with ignored valid_i pulses
    run_op(2, rand_vec(), rand_vec(), 1'b1, 5'd12, 5, got, got_en);

    // Reset in the middle of a divide
    valu_opcode_i = OW'(3);
    operand_v1_i  = rand_vec();
    operand_v2_i  = rand_vec();
    wb_en_i       = 1'b1;
    wb_addr_i     = 5'd22;
    valid_i       = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (7) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_valid", DW'(valid_o), DW'(1'b0));
    check("midrst_ready", DW'(ready_o), DW'(1'b1));
    check("midrst_busy", DW'(busy_o), DW'(1'b0));
    check("midrst_result", result_o, '0);
    check("midrst_wb_en", DW'(wb_en_o), DW'(1'b0));
    check("midrst_wb_addr", DW'(wb_addr_o), DW'(0));
    seen_valid = 1'b0;
    repeat (20) begin
      step();
      if (valid_o) seen_valid = 1'b1;
    end
    check("midrst_no_output", DW'(seen_valid), DW'(1'b0));
    v1 = {LANES{16'h1234}};
    v2 = {LANES{16'h0101}};
    run_op(2, v1, v2, 1'b1, 5'd4, 0, got, got_en);
    check("post_rst_vadd", got, {LANES{16'h1335}});

    // Randomized ops with random backpressure
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 7);
      v1 = rand_vec();
      v2 = rand_vec();
      if (op == 3) begin
        for (int i = 0; i < LANES; i++) begin
          case ($urandom_range(0, 7))
            0: v1[i*16 +: 16] = 16'h0000;
            1: begin v1[i*16 +: 16] = 16'hFFFF; v2[i*16 +: 16] = 16'h8000; end
            2: v1[i*16 +: 16] = 16'($urandom_range(1, 20));
            default: ;
          endcase
        end
      end
      run_op(op, v1, v2, 1'($urandom_range(0, 1)), AW'($urandom), $urandom_range(0, 3), got, got_en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
